// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the shared-multiplier arbiter.
// Optional statistics outputs are enabled with MULT_SHARE_ARB_STATS_EN.
package mult_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_NREQ  = 4;

   function automatic int idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/booth_mult.sv
// Combinational radix-4 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH.
// WIDTH must be even.
module booth_mult #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] p
);

   logic [2*WIDTH-1:0] w_ae;
   logic [2*WIDTH-1:0] w_pp;
   logic [2*WIDTH-1:0] w_acc;
   logic [WIDTH:0]     w_be;
   logic [2:0]         w_trip;

   always_comb begin
      w_ae   = {{WIDTH{a[WIDTH-1]}}, a};
      w_be   = {b, 1'b0};
      w_acc  = '0;
      w_pp   = '0;
      w_trip = '0;
      // Multiplicand pre-shifted by 2 per digit instead of indexing.
      for (int k = 0; k < WIDTH / 2; k++) begin
         w_trip = w_be[2:0];
         unique case (w_trip)
            3'b001, 3'b010: w_pp = w_ae;
            3'b011:         w_pp = w_ae << 1;
            3'b100:         w_pp = -(w_ae << 1);
            3'b101, 3'b110: w_pp = -w_ae;
            default:        w_pp = '0;
         endcase
         w_acc = w_acc + w_pp;
         w_ae  = w_ae << 2;
         w_be  = w_be >> 2;
      end
      p = w_acc;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid request at or after ptr.
// Returns a one-hot grant, its encoded index and an any-grant flag.
module rr_arbiter
   import mult_share_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   localparam int IDW = idw(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   logic [IDW-1:0] w_j;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      w_j = '0;
      for (int off = 0; off < NREQ; off++) begin
         w_j = IDW'((int'(ptr) + off) % NREQ);
         if (!any && req[w_j]) begin
            any      = 1'b1;
            gnt[w_j] = 1'b1;
            idx      = w_j;
         end
      end
   end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sequencer sharing one Booth multiplier among NREQ requesters.
// Define MULT_SHARE_ARB_STATS_EN for stat_grants / stat_stall outputs.
module mult_share_arb
   import mult_share_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NREQ    = DEF_NREQ,
   parameter int MUL_CYC = 1,
   localparam int IDW    = idw(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_x,
   input  logic [NREQ*WIDTH-1:0] req_y,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [2*WIDTH-1:0]    rsp_p,
   output logic [IDW-1:0]        rsp_id
`ifdef MULT_SHARE_ARB_STATS_EN
   ,
   output logic [31:0]           stat_grants,
   output logic [31:0]           stat_stall
`endif
);

   localparam logic [2:0] CNT_LAST = 3'(MUL_CYC - 1);

   state_t r_state;
   state_t w_next;

   logic [2:0]         r_cnt;
   logic [WIDTH-1:0]   r_x;
   logic [WIDTH-1:0]   r_y;
   logic [IDW-1:0]     r_id;
   logic [IDW-1:0]     r_ptr;
   logic               r_rsp_valid;
   logic [2*WIDTH-1:0] r_rsp_p;
   logic [IDW-1:0]     r_rsp_id;

   logic [NREQ-1:0]    w_gnt;
   logic [IDW-1:0]     w_idx;
   logic               w_any;
   logic               w_take;
   logic               w_last;
   logic               w_done;
   logic [WIDTH-1:0]   w_xsel;
   logic [WIDTH-1:0]   w_ysel;
   logic [2*WIDTH-1:0] w_prod;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req (req_valid),
      .ptr (r_ptr),
      .gnt (w_gnt),
      .idx (w_idx),
      .any (w_any)
   );

   booth_mult #(.WIDTH(WIDTH)) u_mult (
      .a (r_x),
      .b (r_y),
      .p (w_prod)
   );

   always_comb begin
      w_xsel = '0;
      w_ysel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt[i]) begin
            w_xsel = req_x[i*WIDTH +: WIDTH];
            w_ysel = req_y[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      req_ready = '0;
      w_take    = 1'b0;
      w_last    = 1'b0;
      w_done    = 1'b0;
      unique case (r_state)
         IDLE: begin
            req_ready = w_gnt;
            if (w_any) begin
               w_take = 1'b1;
               w_next = MUL;
            end
         end
         MUL: begin
            if (r_cnt == CNT_LAST) begin
               w_last = 1'b1;
               w_next = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_done = 1'b1;
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_id        <= '0;
         r_ptr       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_p     <= '0;
         r_rsp_id    <= '0;
      end else begin
         if (w_take) begin
            r_x   <= w_xsel;
            r_y   <= w_ysel;
            r_id  <= w_idx;
            r_cnt <= '0;
            r_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
         end
         if (r_state == MUL && !w_last) r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_rsp_valid <= 1'b1;
            r_rsp_p     <= w_prod;
            r_rsp_id    <= r_id;
         end
         if (w_done) r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_p     = r_rsp_p;
   assign rsp_id    = r_rsp_id;

`ifdef MULT_SHARE_ARB_STATS_EN
   logic [31:0] r_grants;
   logic [31:0] r_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grants <= '0;
         r_stall  <= '0;
      end else begin
         if (w_take) r_grants <= r_grants + 1'b1;
         if (r_state == RESP && !rsp_ready) r_stall <= r_stall + 1'b1;
      end
   end

   assign stat_grants = r_grants;
   assign stat_stall  = r_stall;
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: transaction-level model checked every cycle,
// plus directed product, fairness, stall and reset scenarios.
module tb_mult_share_arb;

   localparam int W   = 16;
   localparam int N   = 4;
   localparam int MC  = 1;
   localparam int IDW = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req_valid;
   logic [N-1:0]     req_ready;
   logic [N*W-1:0]   req_x;
   logic [N*W-1:0]   req_y;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [2*W-1:0]   rsp_p;
   logic [IDW-1:0]   rsp_id;
`ifdef MULT_SHARE_ARB_STATS_EN
   logic [31:0]      stat_grants;
   logic [31:0]      stat_stall;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mult_share_arb #(.WIDTH(W), .NREQ(N), .MUL_CYC(MC)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_p     (rsp_p),
      .rsp_id    (rsp_id)
`ifdef MULT_SHARE_ARB_STATS_EN
      ,
      .stat_grants (stat_grants),
      .stat_stall  (stat_stall)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_to(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out", name);
   endtask

   function automatic logic [31:0] prod(input logic [15:0] x,
                                        input logic [15:0] y);
      int sx;
      int sy;
      sx = $signed(x);
      sy = $signed(y);
      return 32'(sx * sy);
   endfunction

   function automatic int winner(input logic [N-1:0] v, input int ptr);
      for (int off = 0; off < N; off++)
         if (v[(ptr + off) % N]) return (ptr + off) % N;
      return -1;
   endfunction

   // Transaction-level reference: idle / busy with edge count since grant.
   bit          m_busy;
   int          m_t;
   int          m_ptr;
   int          m_id;
   logic [31:0] m_p;
   logic [31:0] m_grants;
   logic [31:0] m_stall;
   logic [31:0] obs_p[$];
   int          obs_id[$];

   always @(negedge clk) begin
      int w;
      logic [N-1:0] er;
      if (!rst_n) begin
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_rsp_p", rsp_p, 0);
         chk("rst_rsp_id", rsp_id, 0);
`ifdef MULT_SHARE_ARB_STATS_EN
         chk("rst_stat_grants", stat_grants, 0);
         chk("rst_stat_stall", stat_stall, 0);
`endif
         m_busy   = 0;
         m_t      = 0;
         m_ptr    = 0;
         m_grants = 0;
         m_stall  = 0;
      end else begin
`ifdef MULT_SHARE_ARB_STATS_EN
         chk("stat_grants", stat_grants, m_grants);
         chk("stat_stall", stat_stall, m_stall);
`endif
         if (rsp_valid && rsp_ready) begin
            obs_p.push_back(rsp_p);
            obs_id.push_back(int'(rsp_id));
         end
         if (!m_busy) begin
            w  = winner(req_valid, m_ptr);
            er = (w >= 0) ? N'(1 << w) : '0;
            chk("req_ready", req_ready, er);
            chk("rsp_valid_idle", rsp_valid, 0);
            if (w >= 0) begin
               m_busy = 1;
               m_t    = 0;
               m_id   = w;
               m_p    = prod(req_x[w*W +: W], req_y[w*W +: W]);
               m_ptr  = (w + 1) % N;
               m_grants++;
            end
         end else begin
            chk("req_ready_busy", req_ready, 0);
            chk("rsp_valid", rsp_valid, (m_t >= MC) ? 1 : 0);
            if (m_t >= MC) begin
               chk("rsp_p", rsp_p, m_p);
               chk("rsp_id", rsp_id, m_id);
               if (rsp_ready) m_busy = 0;
               else           m_stall++;
            end else begin
               m_t++;
            end
         end
      end
   end

   task automatic reset_dut();
      @(posedge clk); #1;
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic do_op(input logic [N-1:0] mask, input logic [15:0] x,
                        input logic [15:0] y, input int exp_id,
                        input logic [31:0] exp_p, input string tag);
      int edges;
      int n;
      @(posedge clk); #1;
      obs_p.delete();
      obs_id.delete();
      req_valid = mask;
      for (int i = 0; i < N; i++) begin
         req_x[i*W +: W] = x;
         req_y[i*W +: W] = y;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = '0;
      edges = 1;
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         edges++;
         n++;
      end
      chk({tag, "_latency"}, edges, MC + 1);
      @(posedge clk); #1;
      chk({tag, "_count"}, obs_id.size(), 1);
      if (obs_id.size() >= 1) begin
         chk({tag, "_p"}, obs_p[0], exp_p);
         chk({tag, "_id"}, obs_id[0], exp_id);
      end
   endtask

   task automatic stall_op(input int nst);
      int n;
      logic [31:0] sp;
      logic [IDW-1:0] sid;
      logic [15:0] x;
      logic [15:0] y;
      @(posedge clk); #1;
      obs_p.delete();
      obs_id.delete();
      x = 16'($urandom);
      y = 16'($urandom);
      req_x[2*W +: W] = x;
      req_y[2*W +: W] = y;
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = '1;
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!rsp_valid) fail_to("stall_wait");
      sp  = rsp_p;
      sid = rsp_id;
      chk("stall_id", sid, 2);
      chk("stall_p", sp, prod(x, y));
      for (int k = 0; k < nst; k++) begin
         @(negedge clk);
         chk("stall_p_hold", rsp_p, sp);
         chk("stall_id_hold", rsp_id, sid);
         chk("stall_ready_zero", req_ready, 0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      repeat (3) @(posedge clk);
      #1 chk("stall_consumed_once", obs_id.size(), 1);
   endtask

   initial begin
      int n;
      req_valid = '0;
      req_x     = '0;
      req_y     = '0;
      rsp_ready = 1'b0;
      reset_dut();

      // Literal products pin both the DUT and the model's arithmetic.
      do_op(4'b0001, 16'd3, 16'hFFFB, 0, 32'hFFFFFFF1, "neg");
      do_op(4'b0010, 16'h8000, 16'h8000, 1, 32'h40000000, "minmin");
      do_op(4'b0100, 16'h7FFF, 16'h8000, 2, 32'hC0008000, "maxmin");
      do_op(4'b1000, 16'hFFFF, 16'hFFFF, 3, 32'h00000001, "m1m1");

      reset_dut();
      @(posedge clk); #1;
      obs_p.delete();
      obs_id.delete();
      req_valid = '1;
      req_x = {$urandom, $urandom};
      req_y = {$urandom, $urandom};
      rsp_ready = 1'b1;
      n = 0;
      while (obs_id.size() < 8 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1 req_valid = '0;
      if (obs_id.size() < 8) fail_to("rr_wait");
      else for (int i = 0; i < 8; i++) chk("rr_order", obs_id[i], i % 4);
      repeat (6) @(posedge clk);

      reset_dut();
      stall_op(5);

      reset_dut();
      @(posedge clk); #1;
      req_valid = 4'b0010;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      chk("async_rsp_valid", rsp_valid, 0);
      chk("async_req_ready", req_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_no_rsp", rsp_valid, 0);
      end
      do_op(4'b1010, 16'd7, 16'd6, 1, 32'd42, "ptr_reset");
      do_op(4'b1000, 16'hFFF0, 16'd16, 3, 32'hFFFFFF00, "req3");

      reset_dut();
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         req_valid = N'($urandom);
         req_x = {$urandom, $urandom};
         req_y = {$urandom, $urandom};
         rsp_ready = ($urandom_range(3) != 0);
      end
      @(posedge clk); #1;
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (8) @(posedge clk);

      reset_dut();
      do_op(4'b0001, 16'd2, 16'd9, 0, 32'd18, "st_a");
      do_op(4'b0010, 16'd5, 16'hFFFE, 1, 32'hFFFFFFF6, "st_b");
      stall_op(4);
`ifdef MULT_SHARE_ARB_STATS_EN
      @(negedge clk);
      chk("stat_grants_lit", stat_grants, 3);
      chk("stat_stall_lit", stat_stall, 4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
